bcd_digit_packer: RTL and testbench

Serial BCD digit assembler that sits directly upstream of the combinational BCD-to-binary converter. It accepts one 4-bit BCD digit per handshake, most significant digit first, and packs NUM_DIGITS digits into a right-aligned packed-BCD word. It presents that word to the converter with a valid/ready handshake. Typical source is a keypad or UART digit decoder; typical sink is the 8-bit BCD input of the converter (NUM_DIGITS=2).

---
 rtl/bcd_digit_packer.sv | 104 ++++++++++
 tb/tb_bcd_digit_packer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_packer.sv
// Serial BCD digit packer: MSD-first digits in, right-aligned packed-BCD frame out.
// Optional `DIGIT_CHECK_EN`: reject digits above 9, abort the frame and raise sticky err.
module bcd_digit_packer #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [3:0]              digit_in,
  input  logic                    digit_valid,
  output logic                    digit_ready,
  input  logic                    commit,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    bcd_valid,
  input  logic                    bcd_ready,
  output logic [3:0]              digit_count,
  output logic                    err
);

  localparam int         W    = 4 * NUM_DIGITS;
  localparam logic [3:0] LAST = 4'(NUM_DIGITS);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   bcd_q, bcd_d, shifted;
  logic [3:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           accept, bad_digit;

  generate
    if (NUM_DIGITS == 1) begin : g_load
      assign shifted = digit_in;
    end else begin : g_shift
      assign shifted = {bcd_q[W-5:0], digit_in};
    end
  endgenerate

`ifdef DIGIT_CHECK_EN
  assign bad_digit = (digit_in > 4'd9);
`else
  assign bad_digit = 1'b0;
`endif

  assign accept      = digit_valid && (state_q == COLLECT);
  assign digit_ready = (state_q == COLLECT) && !rst;
  assign bcd_valid   = (state_q == HOLD);
  assign bcd_out     = bcd_q;
  assign digit_count = cnt_q;
  assign err         = err_q;

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (clear) begin
      state_d = COLLECT;
      bcd_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept && bad_digit) begin
            // Invalid digit kills the partial frame; a same-cycle commit has nothing to close.
            bcd_d = '0;
            cnt_d = '0;
            err_d = 1'b1;
          end else if (accept) begin
            bcd_d = shifted;
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1 == LAST) || commit) state_d = HOLD;
          end else if (commit && (cnt_q != 4'd0)) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (bcd_ready) begin
            state_d = COLLECT;
            bcd_d   = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      bcd_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_digit_packer.sv
// Bench for bcd_digit_packer (NUM_DIGITS=2): directed scenarios then random traffic
// against a digit-queue reference model; follows DIGIT_CHECK_EN if defined.
module tb_bcd_digit_packer;

  localparam int N = 2;
  localparam int W = 4 * N;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic         clk = 1'b0;
  logic         rst, clear, digit_valid, commit, bcd_ready;
  logic [3:0]   digit_in;
  logic         digit_ready, bcd_valid, err;
  logic [W-1:0] bcd_out;
  logic [3:0]   digit_count;

  int total = 0;
  int bad   = 0;

  // Reference model: digits of the open frame, hold flag, sticky error.
  int q[$];
  bit holding;
  bit m_err;
  int exp_frames[$];
  int got_frames[$];

  bcd_digit_packer #(.NUM_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .digit_in(digit_in), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .commit(commit),
    .bcd_out(bcd_out), .bcd_valid(bcd_valid), .bcd_ready(bcd_ready),
    .digit_count(digit_count), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int frame_value();
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit rs, input bit cl, input bit dv, input logic [3:0] d,
                      input bit cm, input bit br);
    @(negedge clk);
    rst = rs; clear = cl; digit_valid = dv; digit_in = d; commit = cm; bcd_ready = br;
    #1;
    chk("bcd_out",     32'(bcd_out),     32'(frame_value()));
    chk("digit_count", 32'(digit_count), 32'(q.size()));
    chk("bcd_valid",   32'(bcd_valid),   32'(holding));
    chk("digit_ready", 32'(digit_ready), 32'(!holding && !rs));
    chk("err",         32'(err),         32'(m_err));
    if (bcd_valid && br && !rs && !cl) got_frames.push_back(int'(bcd_out));
    @(posedge clk);
    if (rs || cl) begin
      q.delete(); holding = 0; m_err = 0;
    end else if (holding) begin
      if (br) begin
        exp_frames.push_back(frame_value());
        q.delete(); holding = 0;
      end
    end else if (dv) begin
`ifdef DIGIT_CHECK_EN
      if (d > 4'd9) begin
        q.delete(); m_err = 1;
      end else begin
        q.push_back(int'(d));
        if (q.size() == N || cm) holding = 1;
      end
`else
      q.push_back(int'(d));
      if (q.size() == N || cm) holding = 1;
`endif
    end else if (cm && q.size() > 0) begin
      holding = 1;
    end
  endtask

  initial begin
    int idx;
    logic [3:0] seq [6];
    rst = 1; clear = 0; digit_valid = 0; digit_in = 0; commit = 0; bcd_ready = 0;
    repeat (2) @(posedge clk);
    q.delete(); holding = 0; m_err = 0;
    tick(H, L, L, 4'h0, L, L);                  // reset state

    // 1: two digits, immediate release
    tick(L, L, H, 4'h1, L, H);
    tick(L, L, H, 4'h5, L, H);
    tick(L, L, L, 4'h0, L, H);                  // HOLD 8'h15
    tick(L, L, L, 4'h0, L, H);

    // 2: commit paths
    tick(L, L, H, 4'h7, L, L);
    tick(L, L, L, 4'h0, H, L);
    tick(L, L, L, 4'h0, L, H);                  // 8'h07
    tick(L, L, H, 4'h4, H, L);
    tick(L, L, L, 4'h0, L, H);                  // 8'h04
    tick(L, L, L, 4'h0, H, H);                  // empty commit ignored
    tick(L, L, L, 4'h0, L, H);

    // 3: backpressure with a pending digit
    tick(L, L, H, 4'h9, L, L);
    tick(L, L, H, 4'h3, L, L);
    repeat (5) tick(L, L, H, 4'h2, L, L);
    tick(L, L, H, 4'h2, L, H);                  // release
    tick(L, L, H, 4'h2, L, L);
    tick(L, L, H, 4'h6, L, L);
    tick(L, L, L, 4'h0, L, H);                  // 8'h26

    // 4: out-of-range digit
    tick(L, L, H, 4'h2, L, L);
    tick(L, L, H, 4'hA, L, L);
    tick(L, L, H, 4'h3, L, H);
    tick(L, L, H, 4'h8, L, H);
    tick(L, L, L, 4'h0, L, H);
    tick(L, L, L, 4'h0, L, H);
    tick(L, H, L, 4'h0, L, L);                  // clear
    tick(L, L, L, 4'h0, L, L);

    // 5: reset mid-frame, clear in HOLD
    tick(L, L, H, 4'h6, L, L);
    tick(H, L, H, 4'h1, L, L);
    tick(L, L, L, 4'h0, L, L);
    tick(L, L, H, 4'h4, L, L);
    tick(L, L, H, 4'h5, L, L);
    tick(L, L, L, 4'h0, L, L);                  // HOLD 8'h45
    tick(L, H, L, 4'h0, L, H);                  // clear wins over bcd_ready
    tick(L, L, L, 4'h0, L, H);

    // 6: back-to-back streaming
    seq[0] = 4'h0; seq[1] = 4'h1; seq[2] = 4'h2; seq[3] = 4'h3; seq[4] = 4'h9; seq[5] = 4'h9;
    idx = 0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      bit acc;
      acc = !holding;
      tick(L, L, H, seq[idx], L, H);
      if (acc) idx++;
    end
    chk("stream_consumed", 32'(idx), 32'd6);
    repeat (2) tick(L, L, L, 4'h0, L, H);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      logic [3:0] d;
      d = ($urandom % 5 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      tick(($urandom % 60) == 0, ($urandom % 45) == 0, ($urandom % 4) != 0, d,
           ($urandom % 6) == 0, ($urandom % 3) != 0);
    end

    chk("frame_count", 32'(got_frames.size()), 32'(exp_frames.size()));
    for (int i = 0; i < got_frames.size() && i < exp_frames.size(); i++)
      chk("frame_seq", 32'(got_frames[i]), 32'(exp_frames[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
